adi2axis_capture_sched: RTL and testbench
=========================================

Name: adi2axis_capture_sched

Overview:
- Capture scheduler that sequences the ADC-to-AXIS converter path.
- Decides when the capture window is open (capture_en) and when the stream beat is the last of a burst (tlast).
- Supports repeated bursts, with an optional external trigger per burst and a programmable gap between bursts.
- Sits between the AXI-Lite register bank and the converter. It replaces the ad-hoc ctrl-word decode with a proper FSM in the AXIS clock domain.

Parameters:
- BEAT_W, 32, width of burst length and beat counter.
- BURST_W, 16, width of burst-count configuration and counter.
- GAP_W, 16, width of inter-burst gap configuration and counter.

Ports:
- AXIS_ACLK  in  1  sole clock.
- AXIS_ARESETN  in  1  asynchronous active-low reset.
- cfg_start  in  1  single-cycle start pulse.
- cfg_abort  in  1  single-cycle abort pulse.
- cfg_mode  in  1  0 = immediate, 1 = wait for ext_trig rising edge before each burst.
- cfg_beats  in  BEAT_W  beats per burst; 0 is illegal.
- cfg_bursts  in  BURST_W  bursts per run; 0 = continuous until abort.
- cfg_gap  in  GAP_W  idle cycles between bursts.
- ext_trig  in  1  asynchronous trigger level.
- beat_xfr  in  1  TVALID & TREADY from the converter.
- ovf  in  1  converter overflow indication.
- capture_en  out  1  capture window open.
- tlast  out  1  current beat is the last of the burst.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run completion.
- burst_cnt  out  BURST_W  bursts completed in the current run.
- stat  out  32  {27'h0, err_cfg, err_ovf, aborted, done_sticky, busy}.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs 0, all counters 0, sticky flags 0.
- States: IDLE, WAIT_TRIG, CAPTURE, GAP, DONE.
- Config capture:
  - cfg_beats, cfg_bursts, cfg_gap and cfg_mode are latched into shadow registers on an accepted cfg_start.
  - Later changes to the cfg_* inputs have no effect until the next start.
- Start in IDLE or DONE with cfg_beats != 0:
  - Clear err_ovf, aborted, done_sticky and burst_cnt.
  - Go to CAPTURE if mode = 0, otherwise WAIT_TRIG.
  - capture_en is high on the first cycle after the start pulse when mode = 0.
- Start with cfg_beats == 0: set err_cfg, stay in IDLE. err_cfg clears on the next legal start.
- Start while in WAIT_TRIG, CAPTURE or GAP: ignored.
- ext_trig handling:
  - Passes through a 2-flop synchronizer, then a registered rising-edge detect.
  - An edge seen in WAIT_TRIG moves to CAPTURE.
  - capture_en rises exactly 3 AXIS_ACLK edges after ext_trig is first sampled high.
  - Edges outside WAIT_TRIG are discarded; no queuing.
- CAPTURE:
  - capture_en = 1.
  - beat_cnt increments on beat_xfr.
  - tlast = capture_en & (beat_cnt == beats_sh - 1), combinational from registered state.
- Burst end = beat_xfr & tlast:
  - beat_cnt resets to 0 and burst_cnt increments.
  - If bursts_sh != 0 and burst_cnt + 1 == bursts_sh: go to DONE and pulse done.
  - Else if gap_sh != 0: go to GAP.
  - Else re-arm directly: CAPTURE (capture_en stays high) or WAIT_TRIG.
- GAP:
  - capture_en = 0.
  - Counts gap_sh cycles, then goes to CAPTURE or WAIT_TRIG.
- Continuous mode (bursts_sh == 0): burst_cnt wraps at 2^BURST_W; the run never reaches DONE.
- cfg_beats == 1: tlast is high on every beat of the burst.
- DONE: busy = 0, done_sticky = 1. Behaves like IDLE for starts.
- Abort, from any non-IDLE state:
  - Next edge: IDLE, capture_en = 0, tlast = 0.
  - If abort arrives mid-burst, no tlast is generated and aborted = 1.
  - Abort in the same cycle as start: abort wins and the start is dropped.
  - Abort in the same cycle as a burst-end beat: that transfer completes (burst_cnt increments), then the FSM goes to IDLE with aborted = 1 and no done pulse.
- ovf while capture_en is high sets err_ovf (sticky). Scheduling continues.
- busy = 1 in WAIT_TRIG, CAPTURE and GAP.

Decomposition:
- Shared package adi2axis_pkg holds:
  - the state enum (IDLE = 0, WAIT_TRIG = 1, CAPTURE = 2, GAP = 3, DONE = 4);
  - MODE_IMM / MODE_TRIG constants;
  - stat bit-index constants, shared with the register bank.
- One sub-module, adi2axis_trig_sync: 2-flop synchronizer plus rising-edge pulse, with async active-low reset.

Test Plan:
- Immediate mode, beats = 4, bursts = 2, gap = 3, beat_xfr held high:
  - capture_en high 4 cycles, tlast on the 4th beat, low 3 cycles, high 4 cycles again.
  - done pulses once; burst_cnt = 2; stat = 0x2.
- Trigger mode, beats = 8, bursts = 1:
  - ext_trig raised 5 cycles after start → capture_en rises 3 edges after the sample; tlast on beat 8; done.
  - A second trigger edge during CAPTURE is ignored.
- TREADY backpressure, beats = 3, beat_xfr toggling 1010…:
  - tlast held until the 3rd accepted beat.
  - beat_cnt never advances without beat_xfr.
- Abort after 2 of 5 beats → capture_en 0 next cycle, no tlast, aborted = 1, busy = 0; a later start clears aborted.
- Start with cfg_beats = 0 → err_cfg = 1, busy stays 0.
- Continuous mode, gap = 0, ovf pulsed during capture:
  - capture_en stays high across bursts, tlast every beats-th beat, err_ovf = 1.
  - Abort ends the run without a done pulse.
- Async reset asserted mid-capture → all outputs 0 immediately.

Source files
------------

// File: rtl/adi2axis_pkg.sv
// Shared definitions for the ADC-to-AXIS capture scheduler and its register bank.
package adi2axis_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TRIG = 3'd1,
        CAPTURE   = 3'd2,
        GAP       = 3'd3,
        DONE      = 3'd4
    } state_e;

    localparam logic MODE_IMM  = 1'b0;
    localparam logic MODE_TRIG = 1'b1;

    // Bit positions inside the 32-bit status word.
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;
    localparam int STAT_ERR_OVF = 3;
    localparam int STAT_ERR_CFG = 4;

    function automatic logic is_busy_state(input state_e st);
        return (st == WAIT_TRIG) || (st == CAPTURE) || (st == GAP);
    endfunction

endpackage

// File: rtl/adi2axis_capture_sched_if.sv
// Control/status bundle between the register bank, the converter and the scheduler.
interface adi2axis_capture_sched_if #(
    parameter int BEAT_W  = 32,
    parameter int BURST_W = 16,
    parameter int GAP_W   = 16
);
    logic               cfg_start;
    logic               cfg_abort;
    logic               cfg_mode;
    logic [BEAT_W-1:0]  cfg_beats;
    logic [BURST_W-1:0] cfg_bursts;
    logic [GAP_W-1:0]   cfg_gap;
    logic               ext_trig;
    logic               beat_xfr;
    logic               ovf;
    logic               capture_en;
    logic               tlast;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] burst_cnt;
    logic [31:0]        stat;

    modport master (
        output cfg_start, cfg_abort, cfg_mode, cfg_beats, cfg_bursts, cfg_gap,
               ext_trig, beat_xfr, ovf,
        input  capture_en, tlast, busy, done, burst_cnt, stat
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_mode, cfg_beats, cfg_bursts, cfg_gap,
               ext_trig, beat_xfr, ovf,
        output capture_en, tlast, busy, done, burst_cnt, stat
    );
endinterface

// File: rtl/adi2axis_trig_sync.sv
// Brings the external trigger level into the clock domain and emits a one-cycle
// registered pulse on each rising edge.
module adi2axis_trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_async,
    output logic trig_rise
);
    logic sync1_r;
    logic sync2_r;
    logic sync2_d_r;
    logic rise_r;

    // Two-stage synchronizer, delayed copy and registered edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            sync2_d_r <= 1'b0;
            rise_r    <= 1'b0;
        end else begin
            sync1_r   <= trig_async;
            sync2_r   <= sync1_r;
            sync2_d_r <= sync2_r;
            rise_r    <= sync2_r & ~sync2_d_r;
        end
    end

    assign trig_rise = rise_r;
endmodule

// File: rtl/adi2axis_capture_sched.sv
// Capture scheduler: opens the capture window, marks the last beat of each burst and
// sequences repeated bursts with optional per-burst trigger and inter-burst gap.
module adi2axis_capture_sched
    import adi2axis_pkg::*;
#(
    parameter int BEAT_W  = 32,
    parameter int BURST_W = 16,
    parameter int GAP_W   = 16
) (
    input  logic AXIS_ACLK,
    input  logic AXIS_ARESETN,
    adi2axis_capture_sched_if.slave bus
);
    state_e             state_r;
    state_e             state_n;
    state_e             rearm_st_s;
    logic [BEAT_W-1:0]  beats_sh_r;
    logic [BEAT_W-1:0]  beat_cnt_r;
    logic [BURST_W-1:0] bursts_sh_r;
    logic [BURST_W-1:0] burst_cnt_r;
    logic [BURST_W-1:0] burst_cnt_inc_s;
    logic [GAP_W-1:0]   gap_sh_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic               mode_sh_r;
    logic               capture_en_r;
    logic               busy_r;
    logic               done_r;
    logic               err_cfg_r;
    logic               err_ovf_r;
    logic               aborted_r;
    logic               done_sticky_r;
    logic               trig_rise_s;
    logic               tlast_s;
    logic               burst_end_s;
    logic               last_burst_s;
    logic               gap_end_s;
    logic               start_ok_s;
    logic               start_bad_s;
    logic               abort_run_s;
    logic               enter_done_s;
    logic [31:0]        stat_s;

    adi2axis_trig_sync u_trig_sync (
        .clk        (AXIS_ACLK),
        .rst_n      (AXIS_ARESETN),
        .trig_async (bus.ext_trig),
        .trig_rise  (trig_rise_s)
    );

    // Burst/gap boundary decodes derived from registered counters.
    always_comb begin
        tlast_s         = capture_en_r && (beat_cnt_r == beats_sh_r - BEAT_W'(1));
        burst_end_s     = bus.beat_xfr && tlast_s;
        burst_cnt_inc_s = burst_cnt_r + BURST_W'(1);
        last_burst_s    = (bursts_sh_r != {BURST_W{1'b0}}) && (burst_cnt_inc_s == bursts_sh_r);
        gap_end_s       = (gap_cnt_r == gap_sh_r - GAP_W'(1));
        rearm_st_s      = (mode_sh_r == MODE_TRIG) ? WAIT_TRIG : CAPTURE;
    end

    // State register.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic; abort always wins over start and over re-arming.
    always_comb begin
        state_n      = state_r;
        start_ok_s   = 1'b0;
        start_bad_s  = 1'b0;
        abort_run_s  = 1'b0;
        enter_done_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.cfg_abort) begin
                    state_n = IDLE;
                end else if (bus.cfg_start) begin
                    if (bus.cfg_beats != {BEAT_W{1'b0}}) begin
                        start_ok_s = 1'b1;
                        state_n    = (bus.cfg_mode == MODE_TRIG) ? WAIT_TRIG : CAPTURE;
                    end else begin
                        start_bad_s = 1'b1;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            WAIT_TRIG: begin
                if (bus.cfg_abort) begin
                    abort_run_s = 1'b1;
                    state_n     = IDLE;
                end else if (trig_rise_s) begin
                    state_n = CAPTURE;
                end else begin
                    state_n = WAIT_TRIG;
                end
            end
            CAPTURE: begin
                if (bus.cfg_abort) begin
                    abort_run_s = 1'b1;
                    state_n     = IDLE;
                end else if (burst_end_s) begin
                    if (last_burst_s) begin
                        enter_done_s = 1'b1;
                        state_n      = DONE;
                    end else if (gap_sh_r != {GAP_W{1'b0}}) begin
                        state_n = GAP;
                    end else begin
                        state_n = rearm_st_s;
                    end
                end else begin
                    state_n = CAPTURE;
                end
            end
            GAP: begin
                if (bus.cfg_abort) begin
                    abort_run_s = 1'b1;
                    state_n     = IDLE;
                end else if (gap_end_s) begin
                    state_n = rearm_st_s;
                end else begin
                    state_n = GAP;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Shadow configuration, frozen for the whole run.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            beats_sh_r  <= {BEAT_W{1'b0}};
            bursts_sh_r <= {BURST_W{1'b0}};
            gap_sh_r    <= {GAP_W{1'b0}};
            mode_sh_r   <= 1'b0;
        end else if (start_ok_s) begin
            beats_sh_r  <= bus.cfg_beats;
            bursts_sh_r <= bus.cfg_bursts;
            gap_sh_r    <= bus.cfg_gap;
            mode_sh_r   <= bus.cfg_mode;
        end
    end

    // Beat, burst and gap counters. A burst-end beat completes even under abort.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            beat_cnt_r  <= {BEAT_W{1'b0}};
            burst_cnt_r <= {BURST_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
        end else begin
            if (start_ok_s) begin
                beat_cnt_r  <= {BEAT_W{1'b0}};
                burst_cnt_r <= {BURST_W{1'b0}};
            end else if (burst_end_s) begin
                beat_cnt_r  <= {BEAT_W{1'b0}};
                burst_cnt_r <= burst_cnt_inc_s;
            end else if (abort_run_s) begin
                beat_cnt_r  <= {BEAT_W{1'b0}};
            end else if (capture_en_r && bus.beat_xfr) begin
                beat_cnt_r  <= beat_cnt_r + BEAT_W'(1);
            end
            if ((state_r == GAP) && !gap_end_s) begin
                gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end else begin
                gap_cnt_r <= {GAP_W{1'b0}};
            end
        end
    end

    // Sticky status flags; a legal start clears the run-related ones.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            err_cfg_r     <= 1'b0;
            err_ovf_r     <= 1'b0;
            aborted_r     <= 1'b0;
            done_sticky_r <= 1'b0;
        end else if (start_ok_s) begin
            err_cfg_r     <= 1'b0;
            err_ovf_r     <= 1'b0;
            aborted_r     <= 1'b0;
            done_sticky_r <= 1'b0;
        end else begin
            err_cfg_r     <= err_cfg_r | start_bad_s;
            err_ovf_r     <= err_ovf_r | (bus.ovf & capture_en_r);
            aborted_r     <= aborted_r | abort_run_s;
            done_sticky_r <= done_sticky_r | enter_done_s;
        end
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            capture_en_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            capture_en_r <= (state_n == CAPTURE);
            busy_r       <= is_busy_state(state_n);
            done_r       <= enter_done_s;
        end
    end

    // Status word assembly.
    always_comb begin
        stat_s               = 32'h0000_0000;
        stat_s[STAT_BUSY]    = busy_r;
        stat_s[STAT_DONE]    = done_sticky_r;
        stat_s[STAT_ABORTED] = aborted_r;
        stat_s[STAT_ERR_OVF] = err_ovf_r;
        stat_s[STAT_ERR_CFG] = err_cfg_r;
    end

    assign bus.capture_en = capture_en_r;
    assign bus.tlast      = tlast_s;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.burst_cnt  = burst_cnt_r;
    assign bus.stat       = stat_s;
endmodule

// File: tb/tb_adi2axis_capture_sched.sv
// Directed plus randomized checks of the capture scheduler against a burst-level model.
module tb_adi2axis_capture_sched;
    import adi2axis_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    adi2axis_capture_sched_if #(.BEAT_W(32), .BURST_W(16), .GAP_W(16)) bus ();

    adi2axis_capture_sched #(.BEAT_W(32), .BURST_W(16), .GAP_W(16)) dut (
        .AXIS_ACLK    (clk),
        .AXIS_ARESETN (rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic mode, input int beats, input int bursts, input int gap);
        bus.cfg_mode   = mode;
        bus.cfg_beats  = 32'(beats);
        bus.cfg_bursts = 16'(bursts);
        bus.cfg_gap    = 16'(gap);
        bus.cfg_start  = 1'b1;
        tick();
        bus.cfg_start  = 1'b0;
    endtask

    // Model: each burst stays open until `beats` accepted beats, then `gap` closed cycles.
    // xmode: 0 = beat_xfr always high, 1 = toggling 1010.., 2 = random.
    task automatic run_imm(input int beats, input int bursts, input int gap, input int xmode,
                           input string tag);
        int acc;
        int step;
        int guard;
        bit x;
        pulse_start(MODE_IMM, beats, bursts, gap);
        bus.cfg_beats  = $urandom;
        bus.cfg_bursts = 16'($urandom);
        bus.cfg_gap    = 16'($urandom);
        bus.cfg_mode   = 1'($urandom);
        step = 0;
        for (int b = 0; b < bursts; b++) begin
            acc   = 0;
            guard = 0;
            while (acc < beats && guard < 100) begin
                case (xmode)
                    0:       x = 1'b1;
                    1:       x = (step % 2 == 0);
                    default: x = ($urandom_range(0, 3) != 0);
                endcase
                bus.beat_xfr = x;
                check1({tag, "_cap"}, bus.capture_en, 1'b1);
                check1({tag, "_tlast"}, bus.tlast, acc == beats - 1);
                check32({tag, "_bcnt"}, 32'(bus.burst_cnt), 32'(b));
                tick();
                if (x) acc++;
                step++;
                guard++;
            end
            bus.beat_xfr = 1'b0;
            if (b < bursts - 1) begin
                for (int g = 0; g < gap; g++) begin
                    check1({tag, "_gapcap"}, bus.capture_en, 1'b0);
                    check1({tag, "_gapbusy"}, bus.busy, 1'b1);
                    tick();
                end
            end
        end
        check1({tag, "_done"}, bus.done, 1'b1);
        check1({tag, "_idlebusy"}, bus.busy, 1'b0);
        check1({tag, "_endcap"}, bus.capture_en, 1'b0);
        check32({tag, "_final_bcnt"}, 32'(bus.burst_cnt), 32'(bursts));
        tick();
        check1({tag, "_done_once"}, bus.done, 1'b0);
    endtask

    initial begin
        bus.cfg_start  = 1'b0;
        bus.cfg_abort  = 1'b0;
        bus.cfg_mode   = 1'b0;
        bus.cfg_beats  = 32'd0;
        bus.cfg_bursts = 16'd0;
        bus.cfg_gap    = 16'd0;
        bus.ext_trig   = 1'b0;
        bus.beat_xfr   = 1'b0;
        bus.ovf        = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        check1("rst_cap", bus.capture_en, 1'b0);
        check1("rst_tlast", bus.tlast, 1'b0);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_done", bus.done, 1'b0);
        check32("rst_bcnt", 32'(bus.burst_cnt), 32'd0);
        check32("rst_stat", bus.stat, 32'h0);

        // Immediate mode: 4 beats, 2 bursts, gap 3.
        run_imm(4, 2, 3, 0, "imm");
        check32("imm_stat", bus.stat, 32'h2);

        // Backpressure: tlast held until the third accepted beat.
        run_imm(3, 1, 0, 1, "bp");

        // Trigger mode: 8 beats, 1 burst, trigger 5 cycles after start.
        pulse_start(MODE_TRIG, 8, 1, 0);
        for (int i = 0; i < 5; i++) begin
            check1("trig_wait_busy", bus.busy, 1'b1);
            check1("trig_wait_cap", bus.capture_en, 1'b0);
            tick();
        end
        bus.ext_trig = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check1("trig_latency_low", bus.capture_en, 1'b0);
        end
        tick();
        check1("trig_latency_high", bus.capture_en, 1'b1);
        bus.beat_xfr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) bus.ext_trig = 1'b0;
            if (i == 3) bus.ext_trig = 1'b1;
            check1("trig_cap", bus.capture_en, 1'b1);
            check1("trig_tlast", bus.tlast, i == 7);
            tick();
        end
        bus.beat_xfr = 1'b0;
        check1("trig_done", bus.done, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check1("trig_noretrig_cap", bus.capture_en, 1'b0);
            check1("trig_noretrig_busy", bus.busy, 1'b0);
        end
        bus.ext_trig = 1'b0;

        // Abort after 2 of 5 beats.
        pulse_start(MODE_IMM, 5, 1, 0);
        bus.beat_xfr = 1'b1;
        tick();
        tick();
        bus.beat_xfr  = 1'b0;
        bus.cfg_abort = 1'b1;
        check1("abort_pre_tlast", bus.tlast, 1'b0);
        tick();
        bus.cfg_abort = 1'b0;
        check1("abort_cap", bus.capture_en, 1'b0);
        check1("abort_tlast", bus.tlast, 1'b0);
        check1("abort_busy", bus.busy, 1'b0);
        check1("abort_done", bus.done, 1'b0);
        check1("abort_flag", bus.stat[STAT_ABORTED], 1'b1);
        run_imm(2, 1, 0, 0, "reabort");
        check32("reabort_stat", bus.stat, 32'h2);

        // Abort in the same cycle as start drops the start.
        bus.cfg_abort = 1'b1;
        pulse_start(MODE_IMM, 4, 1, 0);
        bus.cfg_abort = 1'b0;
        check1("abort_start_busy", bus.busy, 1'b0);
        check1("abort_start_cap", bus.capture_en, 1'b0);

        // Illegal beat count.
        pulse_start(MODE_IMM, 0, 1, 0);
        check1("cfg0_err", bus.stat[STAT_ERR_CFG], 1'b1);
        check1("cfg0_busy", bus.busy, 1'b0);
        tick();
        check1("cfg0_busy2", bus.busy, 1'b0);
        run_imm(1, 2, 0, 2, "beat1");
        check32("beat1_stat", bus.stat, 32'h2);

        // Continuous mode, gap 0, ovf during capture, abort on a burst-end beat.
        pulse_start(MODE_IMM, 3, 0, 0);
        bus.beat_xfr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.ovf = (i == 4);
            if (i == 11) bus.cfg_abort = 1'b1;
            check1("cont_cap", bus.capture_en, 1'b1);
            check1("cont_tlast", bus.tlast, (i % 3) == 2);
            check32("cont_bcnt", 32'(bus.burst_cnt), 32'(i / 3));
            check1("cont_done", bus.done, 1'b0);
            tick();
        end
        bus.ovf       = 1'b0;
        bus.cfg_abort = 1'b0;
        bus.beat_xfr  = 1'b0;
        check1("cont_abort_cap", bus.capture_en, 1'b0);
        check1("cont_abort_done", bus.done, 1'b0);
        check32("cont_abort_bcnt", 32'(bus.burst_cnt), 32'd4);
        check32("cont_abort_stat", bus.stat, 32'hC);
        tick();
        check1("cont_abort_done2", bus.done, 1'b0);

        // Randomized immediate-mode runs.
        for (int r = 0; r < 6; r++) begin
            run_imm($urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(0, 3), 2, "rand");
            check32("rand_stat", bus.stat, 32'h2);
        end

        // Asynchronous reset mid-capture.
        pulse_start(MODE_IMM, 8, 1, 0);
        bus.beat_xfr = 1'b1;
        tick();
        tick();
        check1("ares_pre_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("ares_cap", bus.capture_en, 1'b0);
        check1("ares_tlast", bus.tlast, 1'b0);
        check1("ares_busy", bus.busy, 1'b0);
        check1("ares_done", bus.done, 1'b0);
        check32("ares_stat", bus.stat, 32'h0);
        bus.beat_xfr = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check1("ares_after_cap", bus.capture_en, 1'b0);
        check32("ares_after_bcnt", 32'(bus.burst_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
